// File: rtl/pyr_dense_optical_flow_accel_div_34s_17ns_34_seq.sv
// pyr_dense_optical_flow_accel_div_34s_17ns_34_seq: sequential radix-2 restoring signed/unsigned divider with ce stall and valid/ready handshakes
module pyr_dense_optical_flow_accel_div_34s_17ns_34_seq #(
    parameter int DIVIDEND_WIDTH = 34,
    parameter int DIVISOR_WIDTH  = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quot,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic                      div_by_zero
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int SW = DIVISOR_WIDTH;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_neg, r_zero;
    logic [DW-1:0]   r_d;
    logic [SW:0]     r_r;
    logic [SW-1:0]   r_div;
    logic [SW:0]     w_sh, w_sub;
    logic            w_ge, w_last;
    logic [DW-1:0]   w_mag;

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign w_last    = r_cnt == CW'(DW - 1);
    assign w_mag     = din0[DW-1] ? -din0 : din0;
    assign w_sh      = {r_r[SW-1:0], r_d[DW-1]};
    assign w_sub     = w_sh - {1'b0, r_div};
    assign w_ge      = r_r[SW] | (w_sh >= {1'b0, r_div});

    // next-state: accept, iterate DW steps, fix signs, wait for the consumer
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid  ? CALC : IDLE;
            CALC:    w_next = w_last    ? FIX  : CALC;
            FIX:     w_next = DONE;
            default: w_next = out_ready ? IDLE : DONE;
        endcase
    end

    // state register; reset overrides ce and abandons any op in flight
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else if (ce)
            r_state <= w_next;
    end

    // datapath: quotient bits shift into the dividend register as it empties
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_zero      <= 1'b0;
            r_d         <= '0;
            r_r         <= '0;
            r_div       <= '0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            if (r_state == IDLE && in_valid) begin
                r_neg  <= din0[DW-1];
                r_zero <= din1 == '0;
                r_d    <= w_mag;
                r_div  <= din1;
                r_r    <= '0;
                r_cnt  <= '0;
            end
            if (r_state == CALC) begin
                r_r   <= w_ge ? w_sub : w_sh;
                r_d   <= {r_d[DW-2:0], w_ge};
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == FIX) begin
                quot        <= r_zero ? (r_neg ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                                      : (r_neg ? -r_d : r_d);
                rem         <= r_zero ? '0 : (r_neg ? -r_r[SW-1:0] : r_r[SW-1:0]);
                div_by_zero <= r_zero;
            end
        end
    end
endmodule

// File: tb/tb_pyr_dense_optical_flow_accel_div_34s_17ns_34_seq.sv
// tb_pyr_dense_optical_flow_accel_div_34s_17ns_34_seq: directed and stream tests of the sequential divider
module tb_pyr_dense_optical_flow_accel_div_34s_17ns_34_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [33:0] din0 = '0;
    logic [16:0] din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [33:0] quot;
    logic [16:0] rem;
    logic        div_by_zero;
    int          n_tests = 0;
    int          n_fail = 0;

    pyr_dense_optical_flow_accel_div_34s_17ns_34_seq dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [33:0] a, input logic [16:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        din0 = a;
        din1 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int stall_at, input int stall_len, output int lat, output logic ir_bad);
        lat = -1;
        ir_bad = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
            if (in_ready) ir_bad = 1'b1;
            ce = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
        end
        ce = 1'b1;
    endtask

    task automatic pop;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        n_tests++;
        if (quot !== 34'd0 || rem !== 17'd0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: quot=%h rem=%h dbz=%b, want 0 0 0", quot, rem, div_by_zero);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        logic ir_bad;
        start_op(34'd100, 17'd7);
        wait_out(0, 0, lat, ir_bad);
        n_tests++;
        if (lat !== 35) begin n_fail++; $display("FAIL basic_lat: got %0d, want 35", lat); end
        n_tests++;
        if (quot !== 34'd14 || rem !== 17'd2 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_val: quot=%h rem=%h dbz=%b, want e 2 0", quot, rem, div_by_zero);
        end
        n_tests++;
        if (ir_bad !== 1'b0) begin n_fail++; $display("FAIL basic_ready_busy: in_ready rose during CALC, want 0"); end
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done_hold: in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
        end
        pop();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_signed;
        logic [33:0] a_t [3] = '{-34'sd100, 34'h2_0000_0000, 34'h1_FFFF_FFFF};
        logic [16:0] b_t [3] = '{17'd7, 17'd1, 17'd131071};
        logic [33:0] q_t [3] = '{-34'sd14, 34'h2_0000_0000, 34'd65536};
        logic [16:0] r_t [3] = '{-17'sd2, 17'd0, 17'd65535};
        int lat;
        logic ir_bad;
        for (int i = 0; i < 3; i++) begin
            start_op(a_t[i], b_t[i]);
            wait_out(0, 0, lat, ir_bad);
            n_tests++;
            if (lat !== 35 || quot !== q_t[i] || rem !== r_t[i] || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL signed_%0d: lat=%0d quot=%h rem=%h dbz=%b, want 35 %h %h 0",
                         i, lat, quot, rem, div_by_zero, q_t[i], r_t[i]);
            end
            pop();
        end
    endtask

    task automatic test_div_zero;
        logic [33:0] a_t [2] = '{34'd5, -34'sd5};
        logic [33:0] q_t [2] = '{34'h1_FFFF_FFFF, 34'h2_0000_0000};
        int lat;
        logic ir_bad;
        for (int i = 0; i < 2; i++) begin
            start_op(a_t[i], 17'd0);
            wait_out(0, 0, lat, ir_bad);
            n_tests++;
            if (lat !== 35 || quot !== q_t[i] || rem !== 17'd0 || div_by_zero !== 1'b1) begin
                n_fail++;
                $display("FAIL divzero_%0d: lat=%0d quot=%h rem=%h dbz=%b, want 35 %h 0 1",
                         i, lat, quot, rem, div_by_zero, q_t[i]);
            end
            pop();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic ir_bad;
        start_op(34'd1000, 17'd3);
        wait_out(0, 0, lat, ir_bad);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || quot !== 34'd333 || rem !== 17'd1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_%0d: ov=%b quot=%h rem=%h ir=%b, want 1 14d 1 0",
                         i, out_valid, quot, rem, in_ready);
            end
        end
        pop();
    endtask

    task automatic test_ce_stall;
        int lat;
        logic ir_bad;
        start_op(34'd50, 17'd6);
        wait_out(10, 5, lat, ir_bad);
        n_tests++;
        if (lat !== 40 || quot !== 34'd8 || rem !== 17'd2) begin
            n_fail++;
            $display("FAIL ce_stall: lat=%0d quot=%h rem=%h, want 40 8 2", lat, quot, rem);
        end
        pop();
    endtask

    task automatic test_reset_abort;
        int lat;
        logic ir_bad;
        start_op(34'd9999, 17'd3);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== 34'd0) begin
            n_fail++;
            $display("FAIL abort_state: ir=%b ov=%b quot=%h, want 1 0 0", in_ready, out_valid, quot);
        end
        start_op(34'd77, 17'd5);
        wait_out(0, 0, lat, ir_bad);
        n_tests++;
        if (lat !== 35 || quot !== 34'd15 || rem !== 17'd2 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next: lat=%0d quot=%h rem=%h dbz=%b, want 35 f 2 0", lat, quot, rem, div_by_zero);
        end
        pop();
    endtask

    task automatic test_back_to_back;
        localparam int N = 1000;
        logic [33:0] a_v [N];
        logic [16:0] b_v [N];
        logic [33:0] eq [N];
        logic [16:0] er [N];
        logic        ez [N];
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        logic acc, done;
        for (int i = 0; i < N; i++) begin
            bit [63:0] t;
            longint av, bv, mag, q, r;
            t = {$urandom(), $urandom()};
            a_v[i] = (i % 4 == 0) ? 34'($signed($urandom_range(2000, 0)) - 1000) : t[33:0];
            b_v[i] = (i % 16 == 5) ? 17'd0 : (i % 8 == 3) ? 17'($urandom_range(131071, 1)) : 17'($urandom_range(300, 1));
            av = longint'($signed(a_v[i]));
            bv = longint'(b_v[i]);
            if (bv == 0) begin
                q = (av < 0) ? -(longint'(1) << 33) : (longint'(1) << 33) - 1;
                r = 0;
            end else begin
                mag = (av < 0) ? -av : av;
                q = mag / bv;
                r = mag % bv;
                if (av < 0) begin q = -q; r = -r; end
            end
            eq[i] = q[33:0];
            er[i] = r[16:0];
            ez[i] = bv == 0;
        end
        while (out_idx < N && cyc < 60000) begin
            in_valid = in_idx < N;
            if (in_idx < N) begin din0 = a_v[in_idx]; din1 = b_v[in_idx]; end
            out_ready = 1'($urandom_range(1, 0));
            @(negedge clk);
            acc = in_valid && in_ready;
            done = out_valid && out_ready;
            if (done) begin
                longint lhs;
                logic id_bad;
                lhs = longint'($signed(quot)) * longint'(b_v[out_idx]) + longint'($signed(rem));
                id_bad = b_v[out_idx] != 0 && b_v[out_idx] <= 17'd65536 && lhs != longint'($signed(a_v[out_idx]));
                n_tests++;
                if (quot !== eq[out_idx] || rem !== er[out_idx] || div_by_zero !== ez[out_idx] || id_bad) begin
                    n_fail++;
                    $display("FAIL stream_%0d: a=%h b=%h quot=%h rem=%h dbz=%b, want %h %h %b",
                             out_idx, a_v[out_idx], b_v[out_idx], quot, rem, div_by_zero,
                             eq[out_idx], er[out_idx], ez[out_idx]);
                end
                out_idx++;
            end
            if (acc) begin
                n_tests++;
                if (done || in_idx != out_idx) begin
                    n_fail++;
                    $display("FAIL stream_accept_%0d: accepted with %0d in flight, handshake=%b, want 0 0",
                             in_idx, in_idx - out_idx, done);
                end
                in_idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (out_idx != N || in_idx != N) begin
            n_fail++;
            $display("FAIL stream_count: accepted=%0d returned=%0d, want %0d %0d", in_idx, out_idx, N, N);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_backpressure();
        test_ce_stall();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
